// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue/write-back sequencer: opcodes, FSM states
// and the bit layout of the 12-bit three-address instruction word.
package alu_issue_pkg;

    localparam int INSTR_W = 12;
    localparam int FIELD_W = 3;

    // Instruction word layout: {op, rd, rs, rt}
    localparam int OP_LSB = 9;
    localparam int RD_LSB = 6;
    localparam int RS_LSB = 3;
    localparam int RT_LSB = 0;

    localparam logic [FIELD_W-1:0] OP_ADD = 3'b000;
    localparam logic [FIELD_W-1:0] OP_SUB = 3'b001;
    localparam logic [FIELD_W-1:0] OP_AND = 3'b010;
    localparam logic [FIELD_W-1:0] OP_OR  = 3'b011;
    localparam logic [FIELD_W-1:0] OP_XOR = 3'b100;
    localparam logic [FIELD_W-1:0] OP_SLT = 3'b101;
    localparam logic [FIELD_W-1:0] OP_MUL = 3'b110;
    localparam logic [FIELD_W-1:0] OP_SHL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

endpackage

// File: rtl/alu_issue_seq_mul.sv
// Iterative shift-add multiplier: one bit of b per cycle, LSB first, keeping
// only the low WIDTH bits of the product.
module shift_add_mul #(
    parameter int WIDTH      = 8,
    parameter int MUL_CYCLES = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] prod
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

    logic             running_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q;

    logic             active;
    logic [CW-1:0]    cnt_cur;
    logic [WIDTH-1:0] a_cur, b_cur, acc_cur;

    assign active = start || running_q;

    // Iteration 0 runs in the start cycle straight from a/b, so prod carries the
    // finished product during the last iteration and busy is already low there.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        a_cur   = a_q;
        b_cur   = b_q;
        acc_cur = acc_q;
        cnt_cur = cnt_q;
        if (start) begin
            a_cur   = a;
            b_cur   = b;
            acc_cur = '0;
            cnt_cur = '0;
        end
        prod = acc_cur + (b_cur[0] ? a_cur : '0);
        busy = active && (cnt_cur != LAST);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            running_q <= 1'b0;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
        end else if (active) begin
            acc_q     <= prod;
            a_q       <= a_cur << 1;
            b_q       <= b_cur >> 1;
            cnt_q     <= cnt_cur + 1'b1;
            running_q <= busy;
        end
    end

endmodule

// File: rtl/alu_issue_seq.sv
// Serial execute/write-back sequencer beside an 8x8 register file: accepts one
// instruction, reads operands, runs the ALU (multi-cycle MUL) and writes back.
module alu_issue_seq
    import alu_issue_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int AW         = 3,
    parameter int MUL_CYCLES = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [AW-1:0]      RX,
    output logic [AW-1:0]      RY,
    input  logic [WIDTH-1:0]   busX,
    input  logic [WIDTH-1:0]   busY,
    output logic [AW-1:0]      RW,
    output logic               WEN,
    output logic [WIDTH-1:0]   busW,
    output logic               done,
    output logic               flag_z,
    output logic               flag_c
);

    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t state_q, state_d;

    logic [FIELD_W-1:0] op_q;
    logic [WIDTH-1:0]   opa_q, opb_q;
    logic               exec_first_q;

    logic [WIDTH-1:0]   result_d;
    logic               carry_d;
    logic [WIDTH:0]     sum_w, diff_w;

    logic               accept;
    logic               mul_busy;
    logic [WIDTH-1:0]   mul_prod;

    assign accept = instr_valid && instr_ready;

    always_ff @(posedge Clk) begin
        if (Rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_READ;
            S_READ: state_d = S_EXEC;
            S_EXEC: if (op_q != OP_MUL || !mul_busy) state_d = S_WB;
            S_WB:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and write strobes decode only the state register.
    always_comb begin
        instr_ready = (state_q == S_IDLE);
        WEN         = (state_q == S_WB);
        done        = (state_q == S_WB);
    end

    shift_add_mul #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .Clk   (Clk),
        .Rst   (Rst),
        .start (exec_first_q && (op_q == OP_MUL)),
        .a     (opa_q),
        .b     (opb_q),
        .busy  (mul_busy),
        .prod  (mul_prod)
    );

    // Bit WIDTH of the difference is the unsigned borrow (opA < opB).
    assign sum_w  = {1'b0, opa_q} + {1'b0, opb_q};
    assign diff_w = {1'b0, opa_q} - {1'b0, opb_q};

    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        case (op_q)
            OP_ADD: {carry_d, result_d} = sum_w;
            OP_SUB: {carry_d, result_d} = diff_w;
            OP_AND: result_d = opa_q & opb_q;
            OP_OR:  result_d = opa_q | opb_q;
            OP_XOR: result_d = opa_q ^ opb_q;
            OP_SLT: result_d = {{(WIDTH-1){1'b0}}, ($signed(opa_q) < $signed(opb_q))};
            OP_MUL: result_d = mul_prod;
            OP_SHL: result_d = opa_q << opb_q[SHW-1:0];
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            op_q         <= '0;
            RX           <= '0;
            RY           <= '0;
            RW           <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            exec_first_q <= 1'b0;
            busW         <= '0;
            flag_z       <= 1'b0;
            flag_c       <= 1'b0;
        end else begin
            exec_first_q <= (state_q == S_READ);
            if (accept) begin
                op_q <= instr[OP_LSB +: FIELD_W];
                RW   <= instr[RD_LSB +: AW];
                RX   <= instr[RS_LSB +: AW];
                RY   <= instr[RT_LSB +: AW];
            end
            if (state_q == S_READ) begin
                opa_q <= busX;
                opb_q <= busY;
            end
            // Result and flags land on the edge into WB so they are stable while WEN is high.
            if (state_q == S_EXEC && state_d == S_WB) begin
                busW   <= result_d;
                flag_z <= (result_d == '0);
                if (op_q == OP_ADD || op_q == OP_SUB) flag_c <= carry_d;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with a behavioural 8x8 register file model.
module tb_alu_issue_seq;
    import alu_issue_pkg::*;

    localparam int WIDTH = 8;
    localparam int AW    = 3;

    logic               Clk = 1'b0;
    logic               Rst;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [AW-1:0]      RX, RY, RW;
    logic [WIDTH-1:0]   busX, busY, busW;
    logic               WEN, done, flag_z, flag_c;

    always #5 Clk = ~Clk;

    alu_issue_seq #(.WIDTH(8), .AW(3), .MUL_CYCLES(8)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .RX          (RX),
        .RY          (RY),
        .busX        (busX),
        .busY        (busY),
        .RW          (RW),
        .WEN         (WEN),
        .busW        (busW),
        .done        (done),
        .flag_z      (flag_z),
        .flag_c      (flag_c)
    );

    // Register file model: r0 reads as zero, writes to r0 are dropped.
    logic [WIDTH-1:0] regs [0:7] = '{8'h00, 8'h0F, 8'hF3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    int wr_count = 0;

    assign busX = regs[RX];
    assign busY = regs[RY];

    always @(posedge Clk) begin
        if (WEN) begin
            wr_count <= wr_count + 1;
            if (RW != 0) regs[RW] <= busW;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [INSTR_W-1:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                              input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt};
    endfunction

    typedef struct {
        string      name;
        logic [2:0] op, rd, rs, rt;
        logic [7:0] exp_w;
        logic       exp_z, exp_c;
    } vec_t;

    // Called at the first negedge after the accept edge; follows the instruction to WB.
    task automatic finish_instr(input string nm, input logic [2:0] rd, input logic [7:0] exp_w,
                                input logic exp_z, input logic exp_c, input int exp_lat);
        int lat = 1;
        while (!WEN && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        check({nm, " latency"}, lat, exp_lat);
        check({nm, " busW"}, busW, exp_w);
        check({nm, " RW"}, RW, rd);
        check({nm, " done"}, done, 1);
        check({nm, " flag_z"}, flag_z, exp_z);
        check({nm, " flag_c"}, flag_c, exp_c);
        @(negedge Clk);
        check({nm, " WEN one cycle"}, WEN, 0);
        check({nm, " done one cycle"}, done, 0);
        check({nm, " ready back"}, instr_ready, 1);
    endtask

    task automatic run_instr(input string nm, input logic [INSTR_W-1:0] ins, input logic [2:0] rd,
                             input logic [7:0] exp_w, input logic exp_z, input logic exp_c,
                             input int exp_lat);
        int w = 0;
        @(negedge Clk);
        while (!instr_ready && w < 20) begin
            @(negedge Clk);
            w++;
        end
        check({nm, " ready"}, instr_ready, 1);
        instr       = ins;
        instr_valid = 1'b1;
        @(negedge Clk);
        instr_valid = 1'b0;
        finish_instr(nm, rd, exp_w, exp_z, exp_c, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl[14];
        int   ready_hi, wen_cnt, wen_n, wc0;

        tbl[0]  = '{"add",      OP_ADD, 3'd3, 3'd1, 3'd2, 8'h02, 1'b0, 1'b1};
        tbl[1]  = '{"and",      OP_AND, 3'd3, 3'd1, 3'd2, 8'h03, 1'b0, 1'b1};
        tbl[2]  = '{"sub",      OP_SUB, 3'd4, 3'd1, 3'd2, 8'h1C, 1'b0, 1'b1};
        tbl[3]  = '{"sub_zero", OP_SUB, 3'd4, 3'd2, 3'd2, 8'h00, 1'b1, 1'b0};
        tbl[4]  = '{"or",       OP_OR,  3'd5, 3'd1, 3'd2, 8'hFF, 1'b0, 1'b0};
        tbl[5]  = '{"xor",      OP_XOR, 3'd6, 3'd1, 3'd2, 8'hFC, 1'b0, 1'b0};
        tbl[6]  = '{"slt_true", OP_SLT, 3'd6, 3'd2, 3'd1, 8'h01, 1'b0, 1'b0};
        tbl[7]  = '{"add_cy",   OP_ADD, 3'd7, 3'd2, 3'd2, 8'hE6, 1'b0, 1'b1};
        tbl[8]  = '{"shl3",     OP_SHL, 3'd7, 3'd1, 3'd2, 8'h78, 1'b0, 1'b1};
        tbl[9]  = '{"slt_fals", OP_SLT, 3'd3, 3'd1, 3'd2, 8'h00, 1'b1, 1'b1};
        tbl[10] = '{"add_r0",   OP_ADD, 3'd3, 3'd0, 3'd1, 8'h0F, 1'b0, 1'b0};
        tbl[11] = '{"xor_rd0",  OP_XOR, 3'd0, 3'd1, 3'd1, 8'h00, 1'b1, 1'b0};
        tbl[12] = '{"mul",      OP_MUL, 3'd5, 3'd1, 3'd2, 8'h3D, 1'b0, 1'b0};
        tbl[13] = '{"shl7",     OP_SHL, 3'd3, 3'd2, 3'd1, 8'h80, 1'b0, 1'b0};

        // Reset with a valid instruction presented: it must not be taken.
        Rst         = 1'b1;
        instr_valid = 1'b1;
        instr       = mk(OP_ADD, 3'd3, 3'd1, 3'd2);
        repeat (3) @(negedge Clk);
        check("reset outputs", {WEN, done, flag_z, flag_c, busW, RX, RY, RW}, 0);
        check("reset ready", instr_ready, 1);
        Rst         = 1'b0;
        instr_valid = 1'b0;
        repeat (5) @(negedge Clk);
        check("reset no accept", wr_count, 0);

        foreach (tbl[i]) begin
            run_instr(tbl[i].name, mk(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].rt), tbl[i].rd,
                      tbl[i].exp_w, tbl[i].exp_z, tbl[i].exp_c, (tbl[i].op == OP_MUL) ? 10 : 3);
        end
        check("regfile r7", regs[7], 8'h78);
        check("regfile r5", regs[5], 8'h3D);

        // MUL with a second instruction held valid throughout.
        @(negedge Clk);
        check("mulq ready", instr_ready, 1);
        instr       = mk(OP_MUL, 3'd5, 3'd1, 3'd2);
        instr_valid = 1'b1;
        @(negedge Clk);
        instr    = mk(OP_ADD, 3'd3, 3'd1, 3'd2);
        ready_hi = 0;
        wen_cnt  = 0;
        wen_n    = 0;
        for (int n = 1; n <= 10; n++) begin
            if (n > 1) @(negedge Clk);
            if (instr_ready) ready_hi++;
            if (WEN) begin
                wen_cnt++;
                wen_n = n;
            end
        end
        check("mulq ready low", ready_hi, 0);
        check("mulq latency", wen_n, 10);
        check("mulq single WEN", wen_cnt, 1);
        check("mulq busW", busW, 8'h3D);
        check("mulq RW", RW, 3'd5);
        @(negedge Clk);
        check("mulq idle ready", instr_ready, 1);
        check("mulq idle WEN", WEN, 0);
        @(negedge Clk);
        instr_valid = 1'b0;
        finish_instr("mulq add", 3'd3, 8'h02, 1'b0, 1'b1, 3);

        // Reset in the middle of a MUL: no write, all outputs cleared.
        @(negedge Clk);
        instr       = mk(OP_MUL, 3'd6, 3'd1, 3'd2);
        instr_valid = 1'b1;
        @(negedge Clk);
        instr_valid = 1'b0;
        repeat (3) @(negedge Clk);
        wc0 = wr_count;
        Rst = 1'b1;
        @(negedge Clk);
        check("abort outputs", {WEN, done, flag_z, flag_c, busW, RX, RY, RW}, 0);
        check("abort ready", instr_ready, 1);
        Rst = 1'b0;
        repeat (12) @(negedge Clk);
        check("abort no write", wr_count, wc0);
        run_instr("post abort add", mk(OP_ADD, 3'd3, 3'd1, 3'd2), 3'd3, 8'h02, 1'b0, 1'b1, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Multi-cycle execute/write-back sequencer that sits beside the 8-entry x 8-bit register file, on both its read and write ports.
- Accepts one 3-address instruction over a valid/ready handshake and drives the register-file read addresses.
- Captures both operands, computes an 8-bit ALU result (multiply takes several cycles), then writes the result back through the register-file write port.
- Strictly serial: one instruction in flight, so there are no hazards to resolve.

Parameters:
- WIDTH, 8, data width of operands and results.
- AW, 3, register address width (2**AW registers).
- MUL_CYCLES, 8, multiply iteration count (must equal WIDTH).

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  synchronous active-high reset.
- instr_valid  input  1  instruction present on instr.
- instr_ready  output  1  block can accept an instruction.
- instr  input  12  fields {op[11:9], rd[8:6], rs[5:3], rt[2:0]}.
- RX  output  AW  read address A to the register file (= latched rs).
- RY  output  AW  read address B to the register file (= latched rt).
- busX  input  WIDTH  read data A (combinational from the register file).
- busY  input  WIDTH  read data B.
- RW  output  AW  write address (= latched rd).
- WEN  output  1  write enable, high exactly one cycle per instruction.
- busW  output  WIDTH  write data.
- done  output  1  one-cycle pulse, coincident with WEN.
- flag_z  output  1  result == 0; updated in WB.
- flag_c  output  1  ADD carry-out / SUB borrow; updated in WB for ADD/SUB only, otherwise held.

Behaviour:
- Reset (Rst high at an edge):
  - state = IDLE; instr_ready = 1.
  - WEN, done, flag_z, flag_c, busW, RX, RY, RW = 0.
  - Any in-flight instruction is aborted and no write occurs.
- Rst overrides the handshake: instr_valid during reset is not accepted.
- FSM states: IDLE, READ, EXEC, WB.
- IDLE:
  - instr_ready = 1.
  - On instr_valid && instr_ready at an edge: latch instr and go to READ.
  - instr_ready is low in all other states; instr_valid there is ignored and must be held by the producer.
- READ:
  - RX/RY are driven from the latched rs/rt (RX/RY are registered from the latch, valid from READ onward).
  - At the end of READ, capture busX -> opA and busY -> opB; go to EXEC.
  - A read of register 0 yields 0, as supplied by the register file; no special-casing here.
- EXEC, single-cycle ops: compute the result into a result register; go to WB.
- EXEC, MUL:
  - Shift-add, one bit of opB per cycle, LSB first, for MUL_CYCLES cycles; the result is the low WIDTH bits.
  - The iteration counter runs 0..MUL_CYCLES-1, then the FSM goes to WB.
- Opcodes (arithmetic modulo 2**WIDTH):
  - 000 ADD: opA+opB; c = carry out.
  - 001 SUB: opA-opB; c = 1 iff opA < opB (unsigned).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLT: 1 iff signed(opA) < signed(opB), else 0.
  - 110 MUL: low byte of the product.
  - 111 SHL: opA << opB[2:0]; opB[7:3] are ignored.
- WB:
  - WEN = 1, RW = rd, busW = result, done = 1; the flags are updated.
  - Next state is IDLE; instr_ready returns to 1 the following cycle.
  - rd = 0 is still written; the register file masks reads of register 0.
- Latency from the accept edge to the write edge:
  - Non-MUL: 3 cycles (READ, EXEC, WB).
  - MUL: 10 cycles (READ, 8x EXEC, WB).
  - Throughput: one instruction per 4 cycles (non-MUL) or per 11 cycles (MUL), including the IDLE accept cycle.
- Same-register operands (rs = rt = rd) need no special handling: the operands were captured before the write.
- Outputs are registered; no combinational path from instr or busX/busY to any output.

Decomposition:
- Shared package alu_issue_pkg:
  - opcode localparams OP_ADD..OP_SHL.
  - state encoding (IDLE/READ/EXEC/WB).
  - instr field bit positions.
- One sub-module, shift_add_mul:
  - inputs: start, a, b.
  - outputs: busy, prod[WIDTH-1:0].
  - Instantiated in EXEC; all other ops stay inline.

Test Plan:
- The bench uses a behavioural register model answering RX/RY combinationally (r1=0x0F, r2=0xF3, r0=0) and capturing WEN writes.
- ADD r3=r1+r2 (instr 0x0CA) -> WEN high exactly 3 cycles after accept, RW=3, busW=0x02, flag_c=1, flag_z=0, done coincident.
- SUB r4=r1-r2 -> busW=0x1C, flag_c=1; SUB r4=r2-r2 -> busW=0x00, flag_z=1, flag_c=0.
- MUL r5=r1*r2 -> busW=0x3D (0x0F*0xF3=0xE3D), WEN 10 cycles after accept; instr_ready low throughout, and a second instr_valid asserted meanwhile is accepted only after WB.
- SLT r6=r2<r1 (signed: -13<15) -> busW=0x01; SHL r7=r1<<r2 (shift 3) -> busW=0x78.
- Assert Rst during a MUL EXEC cycle -> no WEN pulse at all, all outputs 0 the next cycle, instr_ready=1; a following ADD completes normally.
